mul_div_unit: RTL and testbench

// - Multi-cycle RV32M/RV64M execute unit, sitting beside the single-cycle ALU.
// - Takes the 5-bit aluControl codes 0xA-0x11 from the ALU decoder:
//   mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
// - Core: iterative radix-2 shift-add multiplier and restoring divider.
// - Uses a start/busy/done handshake so the control path can stall while it runs.

---
 rtl/mul_div_unit.sv | 130 +++++++++++++
 tb/tb_mul_div_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider behind a start/busy/done handshake.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      aluControl,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(XLEN-1);
  localparam logic [XLEN-1:0] MINNEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   opd;   // multiplicand (mul ops) or divisor (div ops)
  logic [2*XLEN-1:0] acc;   // product, or {remainder, quotient}

  // op decode: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
  logic [2:0]      op_sel;
  logic            op_ok, sa, sb, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    op_sel = 3'd0;
    op_ok  = 1'b1;
    case (aluControl)
      5'h0A: op_sel = 3'd0;
      5'h0B: op_sel = 3'd1;
      5'h0C: op_sel = 3'd2;
      5'h0D: op_sel = 3'd3;
      5'h0E: op_sel = 3'd4;
      5'h0F: op_sel = 3'd5;
      5'h10: op_sel = 3'd6;
      5'h11: op_sel = 3'd7;
      default: op_ok = 1'b0;
    endcase
  end

  assign sa       = (op_sel == 3'd1) || (op_sel == 3'd2) || (op_sel == 3'd4) || (op_sel == 3'd6);
  assign sb       = (op_sel == 3'd1) || (op_sel == 3'd4) || (op_sel == 3'd6);
  assign a_neg    = sa & srcA[XLEN-1];
  assign b_neg    = sb & srcB[XLEN-1];
  assign a_mag    = a_neg ? -srcA : srcA;
  assign b_mag    = b_neg ? -srcB : srcB;
  assign div0     = op_sel[2] && (srcB == '0);
  assign ovf      = ((op_sel == 3'd4) || (op_sel == 3'd6)) && (srcA == MINNEG) && (&srcB);
  // op_sel[1] selects remainder among div ops
  assign spec_res = op_sel[1] ? (div0 ? srcA : '0) : (div0 ? '1 : srcA);

  // one iteration of either datapath
  logic [XLEN:0]     msum, rem_sh;
  logic [XLEN-1:0]   rsub;
  logic              ge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt;

  assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opd : '0)};
  assign mul_nxt = {msum, acc[XLEN-1:1]};
  assign rem_sh  = acc[2*XLEN-1:XLEN-1];
  assign ge      = rem_sh >= {1'b0, opd};
  assign rsub    = rem_sh[XLEN-1:0] - opd;
  assign div_nxt = {(ge ? rsub : rem_sh[XLEN-1:0]), acc[XLEN-2:0], ge};
  assign acc_nxt = op[2] ? div_nxt : mul_nxt;

  // sign fix-up applied to the final iteration's value
  logic [XLEN-1:0] hi, lo, hi_neg, w, fin;
  assign hi     = acc_nxt[2*XLEN-1:XLEN];
  assign lo     = acc_nxt[XLEN-1:0];
  assign hi_neg = ~hi + {{(XLEN-1){1'b0}}, (lo == '0)};
  assign w      = op[1] ? hi : lo;

  always_comb begin
    fin = neg ? -w : w;
    case (op)
      3'd0:             fin = lo;
      3'd1, 3'd2, 3'd3: fin = neg ? hi_neg : hi;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= 3'd0;
      neg    <= 1'b0;
      opd    <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start && op_ok) begin
          op  <= op_sel;
          cnt <= '0;
          if (div0 || ovf) begin
            result <= spec_res;
            state  <= DONE;
          end else begin
            neg   <= (op_sel[2] & op_sel[1]) ? a_neg : (a_neg ^ b_neg);
            opd   <= op_sel[2] ? b_mag : a_mag;
            acc   <= {{XLEN{1'b0}}, (op_sel[2] ? a_mag : b_mag)};
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result <= fin;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at XLEN=32: results, latency, special divides,
// ignored restart and mid-operation reset.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  aluControl = 5'h0;
  logic [31:0] srcA = '0, srcB = '0;
  logic        busy, done;
  logic [31:0] result;

  int cmp = 0;
  int mis = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .aluControl(aluControl),
    .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // issue one op; lat = cycle of done (start is cycle 0), -1 on timeout
  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat, output logic tail);
    @(negedge clk);
    start = 1'b1; aluControl = c; srcA = a; srcB = b;
    @(posedge clk); #1 start = 1'b0;
    lat = -1; r = 'x;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin lat = n; r = result; break; end
    end
    @(negedge clk);
    tail = done;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    cmp++; if (busy !== 1'b0) begin mis++; $display("FAIL reset_busy got %b want 0", busy); end
    cmp++; if (done !== 1'b0) begin mis++; $display("FAIL reset_done got %b want 0", done); end
    cmp++; if (result !== 32'h0) begin mis++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat; logic tail;
    run_op(5'h0A, 32'd7, 32'hFFFFFFFD, r, lat, tail);
    cmp++; if (r !== 32'hFFFFFFEB) begin mis++; $display("FAIL mul got %h want ffffffeb", r); end
    cmp++; if (lat !== 33) begin mis++; $display("FAIL mul_latency got %0d want 33", lat); end
    cmp++; if (tail !== 1'b0) begin mis++; $display("FAIL done_pulse got %b want 0", tail); end
    run_op(5'h0B, 32'h80000000, 32'h80000000, r, lat, tail);
    cmp++; if (r !== 32'h40000000) begin mis++; $display("FAIL mulh got %h want 40000000", r); end
    run_op(5'h0D, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, tail);
    cmp++; if (r !== 32'hFFFFFFFE) begin mis++; $display("FAIL mulhu got %h want fffffffe", r); end
    run_op(5'h0C, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, tail);
    cmp++; if (r !== 32'hFFFFFFFF) begin mis++; $display("FAIL mulhsu got %h want ffffffff", r); end
    run_op(5'h0B, 32'hFFFFFFFD, 32'd5, r, lat, tail);
    cmp++; if (r !== 32'hFFFFFFFF) begin mis++; $display("FAIL mulh_neg got %h want ffffffff", r); end
    run_op(5'h0D, 32'h00010000, 32'h00030000, r, lat, tail);
    cmp++; if (r !== 32'h00000003) begin mis++; $display("FAIL mulhu_small got %h want 3", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat; logic tail;
    run_op(5'h0E, 32'hFFFFFFF9, 32'd2, r, lat, tail);
    cmp++; if (r !== 32'hFFFFFFFD) begin mis++; $display("FAIL div got %h want fffffffd", r); end
    cmp++; if (lat !== 33) begin mis++; $display("FAIL div_latency got %0d want 33", lat); end
    run_op(5'h10, 32'hFFFFFFF9, 32'd2, r, lat, tail);
    cmp++; if (r !== 32'hFFFFFFFF) begin mis++; $display("FAIL rem got %h want ffffffff", r); end
    run_op(5'h0F, 32'd100, 32'd7, r, lat, tail);
    cmp++; if (r !== 32'd14) begin mis++; $display("FAIL divu got %h want e", r); end
    run_op(5'h11, 32'd100, 32'd7, r, lat, tail);
    cmp++; if (r !== 32'd2) begin mis++; $display("FAIL remu got %h want 2", r); end
    run_op(5'h0E, 32'd7, 32'hFFFFFFFE, r, lat, tail);
    cmp++; if (r !== 32'hFFFFFFFD) begin mis++; $display("FAIL div_negb got %h want fffffffd", r); end
    run_op(5'h10, 32'd7, 32'hFFFFFFFE, r, lat, tail);
    cmp++; if (r !== 32'd1) begin mis++; $display("FAIL rem_negb got %h want 1", r); end
    run_op(5'h0F, 32'hFFFFFFFF, 32'd1, r, lat, tail);
    cmp++; if (r !== 32'hFFFFFFFF) begin mis++; $display("FAIL divu_max got %h want ffffffff", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat; logic tail; int seen;
    run_op(5'h0F, 32'd5, 32'd0, r, lat, tail);
    cmp++; if (r !== 32'hFFFFFFFF) begin mis++; $display("FAIL divu_by0 got %h want ffffffff", r); end
    cmp++; if (lat !== 1) begin mis++; $display("FAIL divu_by0_latency got %0d want 1", lat); end
    run_op(5'h10, 32'd5, 32'd0, r, lat, tail);
    cmp++; if (r !== 32'd5) begin mis++; $display("FAIL rem_by0 got %h want 5", r); end
    cmp++; if (lat !== 1) begin mis++; $display("FAIL rem_by0_latency got %0d want 1", lat); end
    run_op(5'h0E, 32'h80000000, 32'hFFFFFFFF, r, lat, tail);
    cmp++; if (r !== 32'h80000000) begin mis++; $display("FAIL div_ovf got %h want 80000000", r); end
    cmp++; if (lat !== 1) begin mis++; $display("FAIL div_ovf_latency got %0d want 1", lat); end
    run_op(5'h10, 32'h80000000, 32'hFFFFFFFF, r, lat, tail);
    cmp++; if (r !== 32'h0) begin mis++; $display("FAIL rem_ovf got %h want 0", r); end
    // unsupported code must be ignored
    @(negedge clk);
    start = 1'b1; aluControl = 5'h03; srcA = 32'd9; srcB = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    cmp++; if (seen !== 0) begin mis++; $display("FAIL unsupported_ignored got %0d active cycles want 0", seen); end
    cmp++; if (result !== 32'h0) begin mis++; $display("FAIL unsupported_result got %h want 0", result); end
  endtask

  task automatic test_back_to_back();
    int lat; logic b5; logic [31:0] r;
    @(negedge clk);
    start = 1'b1; aluControl = 5'h0E; srcA = 32'd100; srcB = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    lat = -1; b5 = 1'b0; r = 'x;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin lat = n; r = result; break; end
      if (n == 5) begin
        b5 = busy;
        start = 1'b1; aluControl = 5'h0F; srcA = 32'd9; srcB = 32'd3;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    cmp++; if (b5 !== 1'b1) begin mis++; $display("FAIL restart_busy got %b want 1", b5); end
    cmp++; if (r !== 32'd14) begin mis++; $display("FAIL restart_result got %h want e", r); end
    cmp++; if (lat !== 33) begin mis++; $display("FAIL restart_latency got %0d want 33", lat); end
    @(negedge clk);
    cmp++; if (busy !== 1'b0) begin mis++; $display("FAIL restart_idle got %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    int seen; logic [31:0] r; int lat; logic tail;
    @(negedge clk);
    start = 1'b1; aluControl = 5'h0A; srcA = 32'd3; srcB = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n < 10; n++) @(negedge clk);
    cmp++; if (busy !== 1'b1) begin mis++; $display("FAIL pre_reset_busy got %b want 1", busy); end
    reset = 1'b1;
    #1;
    cmp++; if (busy !== 1'b0) begin mis++; $display("FAIL midreset_busy got %b want 0", busy); end
    cmp++; if (done !== 1'b0) begin mis++; $display("FAIL midreset_done got %b want 0", done); end
    cmp++; if (result !== 32'h0) begin mis++; $display("FAIL midreset_result got %h want 0", result); end
    @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    cmp++; if (seen !== 0) begin mis++; $display("FAIL midreset_no_done got %0d want 0", seen); end
    run_op(5'h0F, 32'd100, 32'd7, r, lat, tail);
    cmp++; if (r !== 32'd14) begin mis++; $display("FAIL after_reset got %h want e", r); end
    cmp++; if (lat !== 33) begin mis++; $display("FAIL after_reset_latency got %0d want 33", lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_special();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
